// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction memory owner: boot sequencing and fetch/loader arbitration
module imem_ctrl #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [AWIDTH-1:0] f_addr,
    output logic              f_rsp_valid,
    output logic [DWIDTH-1:0] f_rsp_data,
    input  logic              l_req_valid,
    output logic              l_req_ready,
    input  logic              l_we,
    input  logic [AWIDTH-1:0] l_addr,
    input  logic [DWIDTH-1:0] l_wdata,
    output logic              l_rsp_valid,
    output logic [DWIDTH-1:0] l_rsp_data,
    input  logic              l_done,
    output logic [AWIDTH-1:0] mem_addr,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              running
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] MAXW = SW'(MAX_WAIT);

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve, starve_nxt;
    logic          f_gnt, l_gnt;

    always_comb begin
        f_gnt      = 1'b0;
        l_gnt      = 1'b0;
        state_nxt  = state;
        starve_nxt = '0;
        case (state)
            BOOT: begin
                l_gnt = l_req_valid;
                if (l_done) state_nxt = RUN;
            end
            RUN: begin
                // Loader wins unless fetch has waited MAX_WAIT grants already.
                if (f_req_valid && (starve == MAXW || !l_req_valid)) f_gnt = 1'b1;
                else                                                 l_gnt = l_req_valid;
                if (!f_req_valid || f_gnt)   starve_nxt = '0;
                else if (l_gnt && starve != MAXW) starve_nxt = starve + 1'b1;
                else                          starve_nxt = starve;
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign f_req_ready = f_gnt;
    assign l_req_ready = l_gnt;
    assign running     = (state == RUN);
    assign mem_addr    = f_gnt ? f_addr : (l_gnt ? l_addr : '0);
    assign mem_we      = l_gnt && l_we;
    assign mem_din     = mem_we ? l_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            starve      <= '0;
            f_rsp_valid <= 1'b0;
            f_rsp_data  <= '0;
            l_rsp_valid <= 1'b0;
            l_rsp_data  <= '0;
        end else begin
            state       <= state_nxt;
            starve      <= starve_nxt;
            f_rsp_valid <= f_gnt;
            if (f_gnt) f_rsp_data <= mem_dout;
            l_rsp_valid <= l_gnt && !l_we;
            if (l_gnt && !l_we) l_rsp_data <= mem_dout;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - directed self-checking bench for imem_ctrl
module tb_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req_valid, f_req_ready, f_rsp_valid;
    logic [3:0]  f_addr;
    logic [31:0] f_rsp_data;
    logic        l_req_valid, l_req_ready, l_we, l_rsp_valid, l_done;
    logic [3:0]  l_addr;
    logic [31:0] l_wdata, l_rsp_data;
    logic [3:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_din, mem_dout;
    logic        running;
    logic [31:0] mem [16];

    int checks = 0;
    int failures = 0;

    imem_ctrl #(.DWIDTH(32), .AWIDTH(4), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_addr(f_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_we(l_we),
        .l_addr(l_addr), .l_wdata(l_wdata),
        .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data), .l_done(l_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
        .running(running)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req_valid = 0; f_addr = 0;
        l_req_valid = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_done = 0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (f_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_f_rsp_valid got=%b exp=0", f_rsp_valid); end
        checks++; if (l_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_l_rsp_valid got=%b exp=0", l_rsp_valid); end
        checks++; if (f_rsp_data !== 32'h0) begin failures++; $display("FAIL reset_f_rsp_data got=%h exp=0", f_rsp_data); end
        checks++; if (l_rsp_data !== 32'h0) begin failures++; $display("FAIL reset_l_rsp_data got=%h exp=0", l_rsp_data); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
        rst_n = 1;
        step();
    endtask

    task automatic test_boot_block();
        f_req_valid = 1; f_addr = 4'd2;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (f_req_ready !== 1'b0) begin failures++; $display("FAIL boot_f_ready c=%0d got=%b exp=0", c, f_req_ready); end
            checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL boot_mem_we c=%0d got=%b exp=0", c, mem_we); end
            checks++; if (running !== 1'b0) begin failures++; $display("FAIL boot_running c=%0d got=%b exp=0", c, running); end
            step();
            checks++; if (f_rsp_valid !== 1'b0) begin failures++; $display("FAIL boot_f_rsp_valid c=%0d got=%b exp=0", c, f_rsp_valid); end
        end
        idle();
    endtask

    task automatic test_boot_load();
        for (int i = 0; i < 16; i++) begin
            l_req_valid = 1; l_we = 1; l_addr = 4'(i); l_wdata = 32'hDEAD0000 + 32'(i);
            l_done = (i == 15);
            @(negedge clk);
            checks++; if (l_req_ready !== 1'b1) begin failures++; $display("FAIL load_l_ready i=%0d got=%b exp=1", i, l_req_ready); end
            checks++; if (mem_we !== 1'b1 || mem_addr !== 4'(i) || mem_din !== 32'hDEAD0000 + 32'(i)) begin
                failures++; $display("FAIL load_mem_drive i=%0d got we=%b a=%0d d=%h exp we=1 a=%0d d=%h",
                                     i, mem_we, mem_addr, mem_din, i, 32'hDEAD0000 + 32'(i));
            end
            checks++; if (running !== 1'b0) begin failures++; $display("FAIL load_running_early i=%0d got=%b exp=0", i, running); end
            step();
            checks++; if (l_rsp_valid !== 1'b0) begin failures++; $display("FAIL load_write_rsp i=%0d got=%b exp=0", i, l_rsp_valid); end
        end
        idle();
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL load_running got=%b exp=1", running); end
        l_req_valid = 1; l_we = 0; l_addr = 4'd5;
        @(negedge clk);
        checks++; if (l_req_ready !== 1'b1) begin failures++; $display("FAIL lread_ready got=%b exp=1", l_req_ready); end
        step();
        idle();
        checks++; if (l_rsp_valid !== 1'b1 || l_rsp_data !== 32'hDEAD0005) begin
            failures++; $display("FAIL lread_rsp got v=%b d=%h exp v=1 d=deaD0005", l_rsp_valid, l_rsp_data);
        end
        step();
        checks++; if (l_rsp_valid !== 1'b0 || l_rsp_data !== 32'hDEAD0005) begin
            failures++; $display("FAIL lread_hold got v=%b d=%h exp v=0 d=dead0005", l_rsp_valid, l_rsp_data);
        end
    endtask

    task automatic test_fetch_alone();
        f_req_valid = 1; f_addr = 4'd3;
        @(negedge clk);
        checks++; if (f_req_ready !== 1'b1 || l_req_ready !== 1'b0) begin
            failures++; $display("FAIL fetch_ready got f=%b l=%b exp f=1 l=0", f_req_ready, l_req_ready);
        end
        checks++; if (mem_addr !== 4'd3 || mem_we !== 1'b0) begin
            failures++; $display("FAIL fetch_mem got a=%0d we=%b exp a=3 we=0", mem_addr, mem_we);
        end
        step();
        idle();
        checks++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hDEAD0003) begin
            failures++; $display("FAIL fetch_rsp got v=%b d=%h exp v=1 d=dead0003", f_rsp_valid, f_rsp_data);
        end
        step();
        checks++; if (f_rsp_valid !== 1'b0 || f_rsp_data !== 32'hDEAD0003) begin
            failures++; $display("FAIL fetch_hold got v=%b d=%h exp v=0 d=dead0003", f_rsp_valid, f_rsp_data);
        end
    endtask

    task automatic test_starve();
        logic exp_f;
        f_req_valid = 1; f_addr = 4'd4;
        l_req_valid = 1; l_we = 0; l_addr = 4'd1;
        for (int c = 0; c < 15; c++) begin
            exp_f = (c % 5 == 4);
            @(negedge clk);
            checks++; if (f_req_ready !== exp_f || l_req_ready !== !exp_f) begin
                failures++; $display("FAIL starve_grant c=%0d got f=%b l=%b exp f=%b l=%b", c, f_req_ready, l_req_ready, exp_f, !exp_f);
            end
            step();
            checks++; if (f_rsp_valid !== exp_f || l_rsp_valid !== !exp_f) begin
                failures++; $display("FAIL starve_rsp c=%0d got f=%b l=%b exp f=%b l=%b", c, f_rsp_valid, l_rsp_valid, exp_f, !exp_f);
            end
            if (exp_f) begin
                checks++; if (f_rsp_data !== 32'hDEAD0004) begin failures++; $display("FAIL starve_fdata c=%0d got=%h exp=dead0004", c, f_rsp_data); end
            end else begin
                checks++; if (l_rsp_data !== 32'hDEAD0001) begin failures++; $display("FAIL starve_ldata c=%0d got=%h exp=dead0001", c, l_rsp_data); end
            end
        end
        idle();
        step();
    endtask

    task automatic test_write_then_read();
        l_req_valid = 1; l_we = 1; l_addr = 4'd7; l_wdata = 32'h12345678;
        step();
        idle();
        checks++; if (l_rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_no_rsp got=%b exp=0", l_rsp_valid); end
        f_req_valid = 1; f_addr = 4'd7;
        step();
        idle();
        checks++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'h12345678) begin
            failures++; $display("FAIL wr_then_fetch got v=%b d=%h exp v=1 d=12345678", f_rsp_valid, f_rsp_data);
        end
    endtask

    task automatic test_reset_mid();
        f_req_valid = 1; f_addr = 4'd3;
        step();
        checks++; if (f_rsp_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_rsp got=%b exp=1", f_rsp_valid); end
        rst_n = 0;
        #1;
        checks++; if (f_rsp_valid !== 1'b0 || running !== 1'b0) begin
            failures++; $display("FAIL mid_async got v=%b run=%b exp v=0 run=0", f_rsp_valid, running);
        end
        checks++; if (f_req_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_in_reset got=%b exp=0", f_req_ready); end
        step();
        rst_n = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (f_req_ready !== 1'b0) begin failures++; $display("FAIL mid_boot_block c=%0d got=%b exp=0", c, f_req_ready); end
            step();
        end
        l_done = 1;
        @(negedge clk);
        checks++; if (f_req_ready !== 1'b0) begin failures++; $display("FAIL mid_done_cycle got=%b exp=0", f_req_ready); end
        step();
        l_done = 0;
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL mid_rerun got=%b exp=1", running); end
        @(negedge clk);
        checks++; if (f_req_ready !== 1'b1) begin failures++; $display("FAIL mid_fetch_ready got=%b exp=1", f_req_ready); end
        step();
        idle();
        checks++; if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hDEAD0003) begin
            failures++; $display("FAIL mid_mem_kept got v=%b d=%h exp v=1 d=dead0003", f_rsp_valid, f_rsp_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_boot_block();
        test_boot_load();
        test_fetch_alone();
        test_starve();
        test_write_then_read();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
